add_job_loader: RTL

- Upstream feeder for the memory-summing adder stage.
- Accepts a job as a stream of words over a valid/ready handshake: first a count N, then N data words.
- Writes the job into the shared job RAM, then clears and starts the adder and holds start until the adder reports fin.
- Captures the adder's result and presents it on a valid/ready output.
- Runs back-to-back jobs. The adder never returns to idle on its own, so this block clears it before every job.

---
 rtl/add_job_loader.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/add_job_loader.sv
// add_job_loader: streams a count+data job into the shared RAM,
// runs the summing adder through clear/start and returns its sum.
module add_job_loader #(
  parameter int DATAWIDTH = 3,
  parameter int MEMWIDTH  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DATAWIDTH-1:0] in_data,
  output logic                 in_ready,
  output logic                 we,
  output logic [MEMWIDTH-1:0]  waddr,
  output logic [DATAWIDTH-1:0] wdata,
  output logic                 add_clr,
  output logic                 add_start,
  input  logic                 add_fin,
  input  logic [DATAWIDTH-1:0] add_result,
  output logic                 out_valid,
  output logic [DATAWIDTH-1:0] out_result,
  input  logic                 out_ready,
  output logic                 err
);

  localparam int DEPTH = 2 ** MEMWIDTH;
  localparam int TW    = MEMWIDTH + 1;
  localparam logic [MEMWIDTH-1:0] CNT_ADDR =
    MEMWIDTH'(DEPTH - 1);
  localparam logic [TW-1:0] T_LAST = TW'(DEPTH + 1);

  // FLUSH lets the last RAM write land before the adder is cleared.
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_CLR,
    S_RUN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [MEMWIDTH-1:0]  cnt_q, cnt_d;
  logic [MEMWIDTH-1:0]  idx_q, idx_d;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic                 in_ready_q, in_ready_d;
  logic                 we_q, we_d;
  logic [MEMWIDTH-1:0]  waddr_q, waddr_d;
  logic [DATAWIDTH-1:0] wdata_q, wdata_d;
  logic                 clr_q, clr_d;
  logic                 start_q, start_d;
  logic                 ovld_q, ovld_d;
  logic [DATAWIDTH-1:0] res_q, res_d;
  logic                 err_q, err_d;

  logic                 xfer_in;
  logic                 xfer_out;
  logic                 clamp;
  logic                 last_word;
  logic                 timeout;
  logic [MEMWIDTH-1:0]  n_in;
  logic                 ld_cnt;
  logic                 ld_word;
  logic                 in_run;
  logic                 in_clr;

  assign xfer_in   = in_valid && in_ready_q;
  assign xfer_out  = ovld_q && out_ready;
  assign clamp     = 32'(in_data) > 32'(DEPTH - 1);
  assign n_in      = clamp ? CNT_ADDR : MEMWIDTH'(in_data);
  assign last_word = idx_q == (cnt_q - MEMWIDTH'(1));
  assign timeout   = (tmr_q == T_LAST) && !add_fin;

  assign ld_cnt  = (state_q == S_IDLE) && xfer_in;
  assign ld_word = (state_q == S_LOAD) && xfer_in;
  assign in_run  = state_q == S_RUN;
  assign in_clr  = state_q == S_CLR;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      tmr_q      <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      clr_q      <= 1'b0;
      start_q    <= 1'b0;
      ovld_q     <= 1'b0;
      res_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      tmr_q      <= tmr_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      clr_q      <= clr_d;
      start_q    <= start_d;
      ovld_q     <= ovld_d;
      res_q      <= res_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (xfer_in) begin
          state_d = (n_in == '0) ? S_FLUSH : S_LOAD;
        end
      end
      S_LOAD: begin
        if (xfer_in && last_word) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: state_d = S_CLR;
      S_CLR:   state_d = S_RUN;
      S_RUN: begin
        if (add_fin || timeout) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (xfer_out) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake/control flops follow the next state so they are
  // valid in the same cycle the state is entered.
  always_comb begin
    in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
    clr_d      = state_d == S_CLR;
    start_d    = state_d == S_RUN;
    ovld_d     = state_d == S_DONE;
  end

  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    res_d   = res_q;
    err_d   = err_q;
    unique case (1'b1)
      ld_cnt: begin
        cnt_d   = n_in;
        idx_d   = '0;
        we_d    = 1'b1;
        waddr_d = CNT_ADDR;
        wdata_d = DATAWIDTH'(n_in);
        err_d   = err_q | clamp;
      end
      ld_word: begin
        we_d    = 1'b1;
        waddr_d = idx_q;
        wdata_d = in_data;
        idx_d   = idx_q + MEMWIDTH'(1);
      end
      in_clr: begin
        tmr_d = '0;
      end
      in_run: begin
        tmr_d = tmr_q + TW'(1);
        if (add_fin) begin
          res_d = add_result;
        end else if (timeout) begin
          res_d = '0;
          err_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign in_ready   = in_ready_q;
  assign we         = we_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign add_clr    = clr_q;
  assign add_start  = start_q;
  assign out_valid  = ovld_q;
  assign out_result = res_q;
  assign err        = err_q;

endmodule
